// File: rtl/arb_pkg.sv
// Shared types and the round-robin pick function for the four-way
// decoder-driven arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Searches last_idx+1, last_idx+2, ... wrapping mod NUM_REQ, so the
  // requester served last is considered last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   last_idx);
    logic [IDX_W-1:0] cand;
    logic             found;
    rr_pick = last_idx;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = last_idx + IDX_W'(i);
      if (!found && req[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/grant_decoder_2to4.sv
// 2-to-4 enable decoder turning the registered winner index into a
// one-hot grant vector.
module grant_decoder_2to4
  import arb_pkg::*;
(
  input  logic               en,
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      y[i] = en && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Four-way round-robin arbiter with hold timeout; the one-hot grant is
// decoded from registered index/valid so it never glitches.
module decoder_rr_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout,
  output arb_state_t         state
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  generate
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("decoder_rr_arbiter: MAX_HOLD must be in 1..255");
    end
  endgenerate

  logic [IDX_W-1:0] last_idx;
  logic [CNT_W-1:0] hold_cnt;

  // Handshake: a requester holds req[i] high until it has been served;
  // gnt[i] high means it owns the resource this cycle. Dropping req[i]
  // while granted ends the grant at the next edge; non-winner requests
  // are only looked at while IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      gnt_idx   <= '0;
      last_idx  <= IDX_W'(NUM_REQ - 1);
      hold_cnt  <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (en && (|req)) begin
            gnt_idx   <= rr_pick(req, last_idx);
            last_idx  <= rr_pick(req, last_idx);
            hold_cnt  <= '0;
            gnt_valid <= 1'b1;
            state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          // A drop on the limit cycle counts as a normal release.
          if (!req[gnt_idx]) begin
            gnt_valid <= 1'b0;
            state     <= ARB_IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            gnt_valid <= 1'b0;
            timeout   <= 1'b1;
            state     <= ARB_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          gnt_valid <= 1'b0;
          state     <= ARB_IDLE;
        end
      endcase
    end
  end

  grant_decoder_2to4 u_decoder (
    .en  (gnt_valid),
    .idx (gnt_idx),
    .y   (gnt)
  );

endmodule

// File: doc/decoder_rr_arbiter.md
# decoder_rr_arbiter

Round-robin arbiter that shares one downstream resource among four requesters and drives its one-hot select through a 2-to-4 enable decoder. It picks a winner from `req[3:0]` and registers the 2-bit winner index. It decodes that index, gated by a grant-valid enable, into `gnt[3:0]`. It holds the grant until the winner drops its request or a hold timeout expires. The block sits between requesting agents and the decoder-selected shared datapath.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per winner; legal range 1..255.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  arbitration enable; low blocks new grants only, an active grant runs to completion.
- `req`  in  4  request vector; `req[i]` is level-held by requester i.
- `gnt`  out  4  one-hot grant; `gnt[i] = gnt_valid & (gnt_idx == i)`.
- `gnt_idx`  out  2  registered winner index.
- `gnt_valid`  out  1  grant active; drives the decoder enable.
- `timeout`  out  1  one-cycle pulse when a grant is force-released.

## Operation
- States: IDLE, GRANT.
- **IDLE**
  - If `en & |req`, select the winner by searching from `last_idx+1` upward, wrapping mod 4.
  - Load `gnt_idx`, set `last_idx <= winner`, clear `hold_cnt`, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - `gnt_valid = 1`. `hold_cnt` increments each cycle and saturates at `MAX_HOLD-1`.
  - If `req[gnt_idx] == 0`, go to IDLE (normal release).
  - Else if `hold_cnt == MAX_HOLD-1`, go to IDLE and pulse `timeout` in the next cycle (forced release).
- **Fairness**
  - The pointer update makes the just-served requester lowest priority in the next arbitration.
  - A requester that timed out and still requests waits behind every other active requester.
- **Reset**: state=IDLE, `gnt_idx=0`, `last_idx=3` (so requester 0 wins first), `hold_cnt=0`, `gnt=0`, `gnt_valid=0`, `timeout=0`.
- **Reset mid-grant**: all outputs go low immediately (asynchronous); no `timeout` pulse.
- **`en`**: changes to `en` while in GRANT have no effect on that grant.
- **Request changes during a grant**: requests from non-winners during GRANT are ignored until the next IDLE.
- **Illegal parameter**: `MAX_HOLD=0` is rejected by an elaboration-time check.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- **Grant latency**: `req`/`en` sampled high in IDLE at edge N gives `gnt` high after edge N, i.e. visible in cycle N+1.
- **Release latency**: `req[gnt_idx]` sampled low at edge M gives `gnt` low after edge M.
- **Minimum gap**: at least one IDLE cycle with `gnt == 0` between consecutive grants, including to a different requester. Back-to-back grant period is therefore (hold cycles + 1).
- **Maximum grant length**: exactly `MAX_HOLD` cycles. With `MAX_HOLD=1`, every grant lasts one cycle and then has one idle cycle.
- **Timeout pulse**: `timeout` is high for exactly the first IDLE cycle after a forced release, coincident with `gnt` low.
- **Simultaneous events**: if the winner drops `req` on the same edge the hold limit is reached, the release is normal and `timeout` stays 0.

## Structure
- **Shared package `arb_pkg`**
  - `NUM_REQ = 4`, `IDX_W = 2`.
  - State enum `arb_state_t {ARB_IDLE, ARB_GRANT}`.
  - Function `rr_pick(req, last_idx)` returning the winner index.
- **Sub-module `grant_decoder_2to4`**
  - Combinational; inputs `en`, `idx[1:0]`; output one-hot `y[3:0]`, where `y[i] = en & (idx == i)`.
  - Instantiated once, fed from the registered `gnt_valid` and `gnt_idx` so `gnt` stays glitch-free.
- **Counter width**: `hold_cnt` is `$clog2(MAX_HOLD+1)` bits.

## Test plan
- **Reset priority**: reset, then `req=4'b1111`, `en=1` → grants in order 0,1,2,3,0. Each grant lasts 8 cycles with a 1-cycle gap, and `timeout` pulses after each grant.
- **Normal release and pointer**: `req=4'b0100` held 3 cycles then dropped → `gnt=4'b0100` for 3 cycles, `timeout=0`. Then `req=4'b0101` → requester 0 wins next, because the pointer is now at 2.
- **Enable gating**: `en=0` with `req=4'b0010` → `gnt` stays 0. Raise `en` → `gnt=4'b0010` one cycle later. Drop `en` mid-grant → the grant continues until `req[1]` falls.
- **Simultaneous release and limit**: `MAX_HOLD=4`, `req[3]` dropped on the 4th grant cycle → normal release, `timeout=0`. Held for 5 cycles instead → forced release and a single `timeout` pulse.
- **Asynchronous reset mid-grant**: assert `rst_n=0` while `gnt=4'b1000` → `gnt`, `gnt_valid` and `timeout` go 0 without waiting for a clock edge. After release, requester 0 has first priority again.
- **Continuous checkers**: `gnt` is always one-hot or zero, and `gnt == decode(gnt_valid, gnt_idx)` on every cycle.
